// File: rtl/frv_dmem_arbiter_if.sv
// Single data-memory port bundle: request side driven by a master,
// stall/error/read-data returned by the slave.
interface frv_dmem_arbiter_if;
  logic        cen;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        error;
  logic [31:0] rdata;

  modport master (
    output cen, wen, strb, addr, wdata,
    input  stall, error, rdata
  );

  modport slave (
    input  cen, wen, strb, addr, wdata,
    output stall, error, rdata
  );
endinterface

// File: rtl/frv_dmem_arbiter.sv
// Shares one data-memory port between requester A (LSU) and requester B.
// Grants are combinational and locked across stalled transactions.
module frv_dmem_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int STARVE_MAX  = 4
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  frv_dmem_arbiter_if.slave   a,
  frv_dmem_arbiter_if.slave   b,
  frv_dmem_arbiter_if.master  dmem
);

  typedef enum logic [1:0] {FREE, LOCK_A, LOCK_B} state_e;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  req_e       last_q, last_d;
  logic [3:0] starve_q, starve_d;
  logic       contend_q, contend_d;

  logic gnt_a, gnt_b;
  logic done_a, done_b;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (state_q)
      LOCK_A: gnt_a = 1'b1;
      LOCK_B: gnt_b = 1'b1;
      default: begin
        if (a.cen && b.cen) begin
          if (ROUND_ROBIN) begin
            gnt_a = (last_q == REQ_B);
            gnt_b = (last_q == REQ_A);
          end else begin
            gnt_b = (starve_q == STARVE_LIM);
            gnt_a = !gnt_b;
          end
        end else begin
          gnt_a = a.cen;
          gnt_b = b.cen;
        end
      end
    endcase
  end

  // A lock whose owner drops cen is an abort, so dmem_cen follows the owner's cen.
  assign dmem.cen   = (gnt_a && a.cen) || (gnt_b && b.cen);
  assign dmem.wen   = gnt_a ? a.wen   : (gnt_b ? b.wen   : 1'b0);
  assign dmem.strb  = gnt_a ? a.strb  : (gnt_b ? b.strb  : 4'h0);
  assign dmem.addr  = gnt_a ? a.addr  : (gnt_b ? b.addr  : 32'h0);
  assign dmem.wdata = gnt_a ? a.wdata : (gnt_b ? b.wdata : 32'h0);

  assign a.stall = gnt_a ? dmem.stall : a.cen;
  assign a.error = gnt_a ? dmem.error : 1'b0;
  assign a.rdata = gnt_a ? dmem.rdata : 32'h0;
  assign b.stall = gnt_b ? dmem.stall : b.cen;
  assign b.error = gnt_b ? dmem.error : 1'b0;
  assign b.rdata = gnt_b ? dmem.rdata : 32'h0;

  assign done_a = gnt_a && a.cen && !dmem.stall;
  assign done_b = gnt_b && b.cen && !dmem.stall;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    starve_d  = starve_q;
    contend_d = contend_q;

    unique case (state_q)
      LOCK_A: if (!a.cen || !dmem.stall) state_d = FREE;
      LOCK_B: if (!b.cen || !dmem.stall) state_d = FREE;
      default: begin
        contend_d = a.cen && b.cen;
        if (gnt_a && dmem.stall)      state_d = LOCK_A;
        else if (gnt_b && dmem.stall) state_d = LOCK_B;
      end
    endcase

    if (done_a) last_d = REQ_A;
    if (done_b) last_d = REQ_B;

    // Starvation count only matters in fixed-priority mode.
    if (!ROUND_ROBIN) begin
      if (done_b) begin
        starve_d = 4'h0;
      end else if (done_a && ((state_q == FREE) ? b.cen : contend_q)
                   && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + 4'd1;
      end
    end else begin
      starve_d = 4'h0;
    end
  end

  // NOTE: reset is synchronous here, so it only appears inside the clocked branch.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q   <= FREE;
      last_q    <= REQ_B;
      starve_q  <= 4'h0;
      contend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      starve_q  <= starve_d;
      contend_q <= contend_d;
    end
  end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Directed bench for frv_dmem_arbiter: a round-robin instance and a
// fixed-priority instance (STARVE_MAX=4) driven by hand-computed vectors.
module tb_frv_dmem_arbiter;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  frv_dmem_arbiter_if a_rr ();
  frv_dmem_arbiter_if b_rr ();
  frv_dmem_arbiter_if m_rr ();
  frv_dmem_arbiter_if a_fp ();
  frv_dmem_arbiter_if b_fp ();
  frv_dmem_arbiter_if m_fp ();

  frv_dmem_arbiter #(.ROUND_ROBIN(1'b1), .STARVE_MAX(4)) u_rr (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .a        (a_rr),
    .b        (b_rr),
    .dmem     (m_rr)
  );

  frv_dmem_arbiter #(.ROUND_ROBIN(1'b0), .STARVE_MAX(4)) u_fp (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .a        (a_fp),
    .b        (b_fp),
    .dmem     (m_fp)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    a_rr.cen = 0; a_rr.wen = 0; a_rr.strb = 4'h0; a_rr.addr = 0; a_rr.wdata = 0;
    b_rr.cen = 0; b_rr.wen = 0; b_rr.strb = 4'h0; b_rr.addr = 0; b_rr.wdata = 0;
    m_rr.stall = 0; m_rr.error = 0; m_rr.rdata = 0;
    a_fp.cen = 0; a_fp.wen = 0; a_fp.strb = 4'h0; a_fp.addr = 0; a_fp.wdata = 0;
    b_fp.cen = 0; b_fp.wen = 0; b_fp.strb = 4'h0; b_fp.addr = 0; b_fp.wdata = 0;
    m_fp.stall = 0; m_fp.error = 0; m_fp.rdata = 0;

    tick(); tick();
    g_resetn = 1'b1;

    // Idle after reset
    settle();
    check("idle_dmem_cen", 32'(m_rr.cen), 32'd0);
    check("idle_a_stall",  32'(a_rr.stall), 32'd0);
    check("idle_b_stall",  32'(b_rr.stall), 32'd0);
    check("idle_a_error",  32'(a_rr.error), 32'd0);
    check("idle_a_rdata",  a_rr.rdata, 32'h0);
    check("idle_dmem_addr", m_rr.addr, 32'h0);

    // Round-robin contention: A, B, A, B
    a_rr.cen = 1; a_rr.addr = 32'h100;
    b_rr.cen = 1; b_rr.addr = 32'h200;
    m_rr.rdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("rr_addr_%0d", i), m_rr.addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      check($sformatf("rr_a_stall_%0d", i), 32'(a_rr.stall), (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("rr_b_stall_%0d", i), 32'(b_rr.stall), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_b_rdata_%0d", i), b_rr.rdata, (i % 2 == 0) ? 32'h0 : 32'h1234_5678);
      tick();
    end

    // Uncontended A read, zero latency
    b_rr.cen = 0;
    a_rr.addr = 32'h100; m_rr.rdata = 32'hDEAD_BEEF;
    settle();
    check("ua_dmem_cen",  32'(m_rr.cen), 32'd1);
    check("ua_dmem_addr", m_rr.addr, 32'h100);
    check("ua_a_rdata",   a_rr.rdata, 32'hDEAD_BEEF);
    check("ua_a_stall",   32'(a_rr.stall), 32'd0);
    check("ua_b_stall",   32'(b_rr.stall), 32'd0);
    tick();

    // Lock hold: A stalled 3 cycles while B requests
    a_rr.addr = 32'h300; b_rr.addr = 32'h400; m_rr.stall = 1;
    settle();
    check("lock_addr_0", m_rr.addr, 32'h300);
    tick();
    b_rr.cen = 1;
    for (int i = 1; i < 3; i++) begin
      settle();
      check($sformatf("lock_addr_%0d", i), m_rr.addr, 32'h300);
      check($sformatf("lock_b_stall_%0d", i), 32'(b_rr.stall), 32'd1);
      tick();
    end
    m_rr.stall = 0;
    settle();
    check("lock_done_addr",    m_rr.addr, 32'h300);
    check("lock_done_a_stall", 32'(a_rr.stall), 32'd0);
    tick();
    a_rr.addr = 32'h304;
    settle();
    check("after_lock_b_addr", m_rr.addr, 32'h400);
    check("after_lock_a_stall", 32'(a_rr.stall), 32'd1);
    tick();

    // Error routing to B
    a_rr.cen = 0; b_rr.addr = 32'h500; m_rr.error = 1;
    settle();
    check("err_b_error", 32'(b_rr.error), 32'd1);
    check("err_a_error", 32'(a_rr.error), 32'd0);
    check("err_b_stall", 32'(b_rr.stall), 32'd0);
    tick();
    m_rr.error = 0; b_rr.cen = 0; a_rr.cen = 1; a_rr.addr = 32'h600;
    settle();
    check("err_free_cen",  32'(m_rr.cen), 32'd1);
    check("err_free_addr", m_rr.addr, 32'h600);
    tick();

    // Abort: A locked, then drops cen
    a_rr.addr = 32'h700; m_rr.stall = 1;
    tick();
    a_rr.cen = 0; b_rr.cen = 1; b_rr.addr = 32'h800;
    settle();
    check("abort_dmem_cen", 32'(m_rr.cen), 32'd0);
    check("abort_b_stall",  32'(b_rr.stall), 32'd1);
    tick();
    m_rr.stall = 0;
    settle();
    check("abort_next_cen",  32'(m_rr.cen), 32'd1);
    check("abort_next_addr", m_rr.addr, 32'h800);
    tick();

    // Reset mid-lock: last=A and LOCK_B before reset; A must win afterwards
    b_rr.cen = 0; a_rr.cen = 1; a_rr.addr = 32'hA00;
    tick();
    a_rr.cen = 0; b_rr.cen = 1; b_rr.addr = 32'h900; m_rr.stall = 1;
    tick();
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    a_rr.cen = 1; m_rr.stall = 0;
    settle();
    check("rst_lock_addr",    m_rr.addr, 32'hA00);
    check("rst_lock_b_stall", 32'(b_rr.stall), 32'd1);
    tick();
    a_rr.cen = 0; b_rr.cen = 0;

    // Fixed priority with STARVE_MAX=4: A A A A B repeating
    a_fp.cen = 1; a_fp.addr = 32'hA0;
    b_fp.cen = 1; b_fp.addr = 32'hB0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("fp_addr_%0d", i), m_fp.addr, (i % 5 == 4) ? 32'hB0 : 32'hA0);
      check($sformatf("fp_b_stall_%0d", i), 32'(b_fp.stall), (i % 5 == 4) ? 32'd0 : 32'd1);
      tick();
    end
    a_fp.cen = 0; b_fp.cen = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frv_dmem_arbiter.md
# frv_dmem_arbiter

Two-requester arbiter that shares the core's single data memory port between the load/store unit (requester A) and a secondary master (requester B, e.g. a DMA or trace engine). It sits between both requesters and the `dmem_*` bus. Each requester sees the same cen/wen/stall/error protocol it would see on a private port. Grants are issued combinationally with zero added latency, and are locked across stalled transactions.

## Interface
- `ROUND_ROBIN`, default 1 — 1: alternate on contention; 0: A has fixed priority, with B starvation guard.
- `STARVE_MAX`, default 4 — in fixed-priority mode, number of consecutive contended losses by B before B is forced a grant (1..15).
- `g_clk`  in  1  global clock.
- `g_resetn`  in  1  synchronous active-low reset.
- `a_cen, a_wen`  in  1  requester A chip/write enable.
- `a_strb`  in  4  requester A byte strobe.
- `a_addr, a_wdata`  in  32  requester A address/write data.
- `a_stall, a_error`  out  1  requester A stall/error.
- `a_rdata`  out  32  requester A read data.
- `b_cen, b_wen`  in  1  requester B chip/write enable.
- `b_strb`  in  4  requester B byte strobe.
- `b_addr, b_wdata`  in  32  requester B address/write data.
- `b_stall, b_error`  out  1  requester B stall/error.
- `b_rdata`  out  32  requester B read data.
- `dmem_cen, dmem_wen`  out  1  memory chip/write enable.
- `dmem_strb`  out  4  memory byte strobe.
- `dmem_addr, dmem_wdata`  out  32  memory address/write data.
- `dmem_stall, dmem_error`  in  1  memory stall/error.
- `dmem_rdata`  in  32  memory read data.

## Operation
- Protocol per port: a transaction completes in the cycle where `cen && !stall`. A requester holds all request signals stable while stalled.
- State FSM has three states: `FREE`, `LOCK_A`, `LOCK_B`. There is also a `last` bit (last completed grantee) and a 4-bit `starve` counter.
- Grant in `LOCK_A`: A. Grant in `LOCK_B`: B.
- Grant in `FREE`:
  - Only one requester has cen high: that requester is granted.
  - Both high, `ROUND_ROBIN=1`: grant goes to the requester that is not `last`.
  - Both high, `ROUND_ROBIN=0`: A is granted, unless `starve==STARVE_MAX`, in which case B is granted.
- Memory outputs are a mux of the granted requester's signals. `dmem_cen` equals the granted requester's cen, and is 0 when there is no grant. With no grant, `dmem_addr/wdata/strb/wen` are 0.
- Granted requester receives `dmem_stall`, `dmem_error` and `dmem_rdata`.
- Non-granted requester receives stall=`cen`, error=0 and rdata=0.
- FSM transitions:
  - `FREE`→`LOCK_x` when x is granted and `dmem_stall`=1.
  - `LOCK_x`→`FREE` when `dmem_stall`=0, i.e. the transaction completes, including when it completes with an error.
  - `LOCK_x`→`FREE` also when `x_cen` drops (abort). The memory sees `dmem_cen`=0 in that cycle.
- `last` updates to the grantee on each completed transaction.
- `starve` behaviour:
  - Increments (saturating at `STARVE_MAX`) when B loses a contended `FREE` arbitration that ends in an A completion.
  - Clears on any B completion.
  - Is unused when `ROUND_ROBIN=1`.
- Simultaneous events: a lock release and a new arbitration happen in the same cycle only via `FREE`. The cycle after a release re-arbitrates. No bubble is inserted beyond that.

## Timing
- Reset values: state=`FREE`, `last`=B (so A wins the first tie), `starve`=0.
- All outputs are combinational from inputs and state. With no requests: `dmem_cen`=0, `a_stall`=`b_stall`=0, errors=0, rdata=0.
- Added latency is zero. A single uncontended non-stalled access completes in the same cycle it is requested.
- While locked, the grant holds for every cycle until completion, regardless of the other requester.
- Worst-case wait for B:
  - Round-robin mode: one A transaction.
  - Fixed-priority mode: `STARVE_MAX` A transactions.
- Reset during a lock returns to `FREE` in the next cycle. The memory transaction is abandoned.

## Test plan
- Uncontended A read: `a_cen`=1, addr `0x100`, `dmem_stall`=0, rdata `0xDEADBEEF` -> same cycle `dmem_addr`=`0x100`, `a_rdata`=`0xDEADBEEF`, `a_stall`=0, `b_stall`=0.
- Contention after reset (`ROUND_ROBIN`=1), both requesting for 4 cycles with no memory stall -> grants are A, B, A, B. The loser sees stall=1 each cycle.
- Lock hold: A granted with `dmem_stall`=1 for 3 cycles while B requests -> `dmem_addr` stays at A's address for all 3 cycles. B is granted in the cycle after A completes.
- Fixed priority (`ROUND_ROBIN`=0, `STARVE_MAX`=4), A and B requesting continuously -> four A completions, then one B completion, then the pattern repeats.
- Error routing: B granted with `dmem_error`=1 and `dmem_stall`=0 -> `b_error`=1, `a_error`=0, FSM returns to `FREE`.
- Abort and reset: A locked, `a_cen` drops -> `dmem_cen`=0 that cycle and state=`FREE` next cycle. `g_resetn`=0 mid-lock -> state=`FREE` and `last`=B.
